denorm_shift: RTL
=================

# denorm_shift

Iterative right-shift denormalizer for 16-bit words: the inverse of the leading-zero/normalize path. It takes a normalized word plus a shift count, typically the leading-zero count used to normalize it. It shifts the word right one bit per cycle and restores the original magnitude, with a sticky bit (OR of all bits shifted out) for rounding. It sits in the datapath after the leading-zero/MSB units, behind a valid/ready handshake on each side.

## Interface
Parameters:
- none; widths come from the shared package (WORD = 16 bits, CNT = 5 bits).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request; high only in IDLE and not in reset.
- in_word  input  16  normalized word.
- in_count  input  5  right-shift amount, 0..31.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_word  output  16  in_word >> min(in_count,16).
- out_sticky  output  1  OR of every bit shifted out.
- out_zero  output  1  out_word == 0 (combinational from out_word).

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE:**
  - in_ready = 1.
  - On an edge with in_valid & in_ready: load word = in_word, sticky = 0, cnt = min(in_count,16).
  - Go to DONE if cnt == 0, else SHIFT.
- **SHIFT:**
  - Each edge: sticky |= word[0]; word = word >> 1 (zero fill); cnt = cnt - 1.
  - Go to DONE on the edge where cnt goes 1 -> 0.
  - in_ready = 0; in_valid is ignored.
- **DONE:**
  - out_valid = 1; out_word/out_sticky hold stable.
  - On an edge with out_ready: go to IDLE and drop out_valid.
  - in_ready = 0 (no overlap of requests).
- **Clamp:** counts 16..31 all behave as 16, giving out_word = 0 and out_sticky = |in_word.
- **Round trip:** for any nonzero w, denorm_shift(w << clz(w), clz(w)) = w with sticky 0.
- **Arithmetic:** unsigned logical shift; no sign extension.

## Timing
- **Reset values:**
  - state IDLE, out_valid 0, out_word 0x0000, out_sticky 0, out_zero 1.
  - in_ready is 0 while reset is high and 1 in the first cycle after reset is released.
- **Latency:** for a request accepted at edge k with clamped count n, out_valid is high from edge k+n, or edge k for n = 0.
- **Occupancy:** the block is busy from the accept edge until the out handshake. Throughput is one request per n+2 cycles at best (out_ready held high).
- **out_ready outside DONE:** ignored.
- **Reset mid-operation:**
  - Reset wins over every other event in the same cycle.
  - Any in-flight SHIFT or DONE is discarded and never produces an out_valid pulse.
- **Simultaneous handshakes:** in_valid asserted in the same cycle as a DONE handshake is not accepted; in_ready rises the cycle after.

## Structure
- **Shared package:**
  - WORD width 16 and CNT width 5.
  - MAX_SHIFT = 16.
  - State encoding constants IDLE/SHIFT/DONE, reusable by other multi-cycle datapath units.
- **Sub-module:** a single-step `shift1_sticky` (word, sticky in -> word >> 1, sticky | word[0]) is natural. The FSM, counter and handshake stay in denorm_shift.
- **Registers:** word, sticky, cnt and state, all reset synchronously.

## Test plan
- in_word 0x8000, in_count 3 -> out_word 0x1000, out_sticky 0, out_zero 0, out_valid at accept edge + 3.
- in_word 0x800F, in_count 4 -> out_word 0x0800, out_sticky 1.
- in_word 0xABCD, in_count 0 -> out_word 0xABCD, sticky 0, out_valid at the accept edge itself (1-cycle turnaround).
- in_word 0x0001, in_count 20 -> behaves as 16: out_word 0x0000, out_sticky 1, out_zero 1, after 16 cycles.
- Backpressure:
  - out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0, an asserted in_valid is not accepted.
  - Release out_ready -> IDLE, then the next request completes correctly.
- Reset mid-operation:
  - Assert reset on cycle 2 of a count-8 shift of 0xFF00 -> next cycle IDLE, out_valid 0, out_word 0.
  - Following request 0x4000/count 1 -> 0x2000, sticky 0.

Source files
------------

// File: rtl/denorm_shift_pkg.sv
// denorm_shift_pkg: shared widths, state encoding and helpers for the
// denormalizer and other multi-cycle datapath units.
//   WORD       data word width
//   CNT        shift-count width (holds 0..31)
//   MAX_SHIFT  largest effective shift; larger counts clamp to it
//   ST_*       IDLE/SHIFT/DONE state encoding
package denorm_shift_pkg;

    localparam int unsigned WORD      = 16;
    localparam int unsigned CNT       = 5;
    localparam int unsigned MAX_SHIFT = 16;

    // State encoding shared by multi-cycle datapath units
    localparam int unsigned STATE_W  = 2;
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_SHIFT = 2'd1;
    localparam logic [1:0]  ST_DONE  = 2'd2;

    // Request payload: normalized word plus its right-shift amount
    typedef struct packed {
        logic [WORD-1:0] word;
        logic [CNT-1:0]  count;
    } req_t;

    // Counts beyond the word width all shift everything out
    function automatic logic [CNT-1:0] clamp_count(input logic [CNT-1:0] c);
        return (c > CNT'(MAX_SHIFT)) ? CNT'(MAX_SHIFT) : c;
    endfunction

endpackage

// File: rtl/denorm_shift_if.sv
// denorm_shift_if: request/response handshake bundle for denorm_shift.
//   in_valid/in_ready/in_word/in_count        request side
//   out_valid/out_ready/out_word/out_sticky/out_zero  result side
//   master: the requester/consumer; slave: the denormalizer.
interface denorm_shift_if;
    import denorm_shift_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [WORD-1:0] in_word;
    logic [CNT-1:0]  in_count;
    logic            out_valid;
    logic            out_ready;
    logic [WORD-1:0] out_word;
    logic            out_sticky;
    logic            out_zero;

    modport master (
        output in_valid, in_word, in_count, out_ready,
        input  in_ready, out_valid, out_word, out_sticky, out_zero
    );

    modport slave (
        input  in_valid, in_word, in_count, out_ready,
        output in_ready, out_valid, out_word, out_sticky, out_zero
    );

endinterface

// File: rtl/denorm_shift_shift1_sticky.sv
// denorm_shift_shift1_sticky: one logical right-shift step with sticky
// accumulation (purely combinational).
//   word_i/sticky_i  current word and sticky
//   word_c           word_i >> 1, zero filled
//   sticky_c         sticky_i | word_i[0]
module denorm_shift_shift1_sticky
    import denorm_shift_pkg::*;
(
    input  logic [WORD-1:0] word_i,
    input  logic            sticky_i,
    output logic [WORD-1:0] word_c,
    output logic            sticky_c
);

    assign word_c   = {1'b0, word_i[WORD-1:1]};
    assign sticky_c = sticky_i | word_i[0];

endmodule

// File: rtl/denorm_shift.sv
// denorm_shift: iterative right-shift denormalizer. Accepts a normalized
// word and a shift count, shifts right one bit per cycle restoring the
// original magnitude, and reports a sticky bit of everything shifted out.
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    denorm_shift_if.slave request/result handshake
module denorm_shift
    import denorm_shift_pkg::*;
(
    input  logic clk,
    input  logic reset,
    denorm_shift_if.slave bus
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WORD-1:0]    word_q, word_d;
    logic               sticky_q, sticky_d;
    logic [CNT-1:0]     cnt_q, cnt_d;

    req_t               req;
    logic [CNT-1:0]     load_cnt;
    logic [WORD-1:0]    step_word;
    logic               step_sticky;

    assign req      = {bus.in_word, bus.in_count};
    assign load_cnt = clamp_count(req.count);

    // Single shift step applied each SHIFT cycle
    denorm_shift_shift1_sticky u_step (
        .word_i   (word_q),
        .sticky_i (sticky_q),
        .word_c   (step_word),
        .sticky_c (step_sticky)
    );

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    word_d   = req.word;
                    sticky_d = 1'b0;
                    cnt_d    = load_cnt;
                    state_d  = (load_cnt == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                word_d   = step_word;
                sticky_d = step_sticky;
                cnt_d    = cnt_q - CNT'(1);
                // <= also exits on a zero count so the FSM can never stall here
                if (cnt_q <= CNT'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    // in_ready is masked by reset so nothing is offered while reset is held
    assign bus.in_ready   = (state_q == ST_IDLE) && !reset;
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_word   = word_q;
    assign bus.out_sticky = sticky_q;
    assign bus.out_zero   = (word_q == '0);

endmodule
